// File: rtl/genius_round_ctrl.sv
// Round sequencer for the Genius memory game: plays the colour sequence, times and checks player input.
// Optional build macro GENIUS_PAUSE_EN adds a PAUSE input that freezes the game while busy.
module genius_round_ctrl #(
    parameter int unsigned SIZE       = 4,
    parameter int unsigned LVL_W      = 4,
    parameter int unsigned SEQ_MAX    = 16,
    parameter int unsigned TIMEOUT    = 9,
    parameter int unsigned SHOW_TICKS = 2
) (
    input  logic             CLKT,
    input  logic             R,
    input  logic             START,
    input  logic             TICK,
    input  logic [1:0]       SEQ_COLOR,
    input  logic [3:0]       BTN,
`ifdef GENIUS_PAUSE_EN
    input  logic             PAUSE,
`endif
    output logic [LVL_W-1:0] SEQ_ADDR,
    output logic [3:0]       LED,
    output logic [SIZE-1:0]  TEMPO,
    output logic [LVL_W-1:0] LEVEL,
    output logic             BUSY,
    output logic             WIN,
    output logic             LOSE
);

    // Round length is held one bit wider so SEQ_MAX == 2^LVL_W stays representable.
    localparam int unsigned LW1 = LVL_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_GAP, S_WIN, S_LOSE
    } state_t;

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   addr_q, addr_d;
    logic [LW1-1:0]     level_q, level_d;
    logic [SIZE-1:0]    tempo_q, tempo_d;
    logic [SIZE-1:0]    tick_q, tick_d;
    logic               busy_q, win_q, lose_q;
    logic               pause_c;
    logic               last_c;
    logic [3:0]         exp_c;

    function automatic logic [3:0] one_hot(input logic [1:0] c);
        one_hot = 4'b0001 << c;
    endfunction

    function automatic logic is_busy(input state_t s);
        is_busy = (s != S_IDLE) && (s != S_WIN) && (s != S_LOSE);
    endfunction

`ifdef GENIUS_PAUSE_EN
    assign pause_c = PAUSE && is_busy(state_q);
`else
    assign pause_c = 1'b0;
`endif

    assign exp_c  = one_hot(SEQ_COLOR);
    assign last_c = ({1'b0, addr_q} == (level_q - LW1'(1)));

    // State and datapath registers.
    always_ff @(posedge CLKT) begin
        if (R) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            level_q <= '0;
            tempo_q <= '0;
            tick_q  <= '0;
            busy_q  <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            level_q <= level_d;
            tempo_q <= tempo_d;
            tick_q  <= tick_d;
            busy_q  <= is_busy(state_d);
            win_q   <= (state_d == S_WIN);
            lose_q  <= (state_d == S_LOSE);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        level_d = level_q;
        tempo_d = tempo_q;
        tick_d  = tick_q;
        if (!pause_c) begin
            case (state_q)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (START) begin
                        state_d = S_SHOW_ON;
                        level_d = LW1'(1);
                        addr_d  = '0;
                        tempo_d = '0;
                        tick_d  = '0;
                    end
                end
                S_SHOW_ON: begin
                    if (TICK) begin
                        if (tick_q == SIZE'(SHOW_TICKS - 1)) begin
                            state_d = S_SHOW_OFF;
                            tick_d  = '0;
                        end else begin
                            tick_d = tick_q + SIZE'(1);
                        end
                    end
                end
                S_SHOW_OFF: begin
                    if (TICK) begin
                        tick_d = '0;
                        if (last_c) begin
                            state_d = S_INPUT;
                            addr_d  = '0;
                            tempo_d = '0;
                        end else begin
                            state_d = S_SHOW_ON;
                            addr_d  = addr_q + LVL_W'(1);
                        end
                    end
                end
                S_INPUT: begin
                    // A press takes priority over a coincident TICK.
                    if (BTN != 4'b0000) begin
                        if (BTN == exp_c) begin
                            tempo_d = '0;
                            if (!last_c) begin
                                addr_d = addr_q + LVL_W'(1);
                            end else if (level_q == LW1'(SEQ_MAX)) begin
                                state_d = S_WIN;
                            end else begin
                                state_d = S_GAP;
                                level_d = level_q + LW1'(1);
                                addr_d  = '0;
                                tick_d  = '0;
                            end
                        end else begin
                            state_d = S_LOSE;
                        end
                    end else if (TICK) begin
                        if (tempo_q < SIZE'(TIMEOUT)) begin
                            tempo_d = tempo_q + SIZE'(1);
                        end else begin
                            state_d = S_LOSE;
                        end
                    end
                end
                S_GAP: begin
                    if (TICK) begin
                        state_d = S_SHOW_ON;
                        tick_d  = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // LED follows the memory read directly so each step lights on its first SHOW_ON cycle.
    always_comb begin
        LED = 4'b0000;
        if (state_q == S_SHOW_ON && !pause_c) begin
            LED = exp_c;
        end
    end

    assign SEQ_ADDR = addr_q;
    assign LEVEL    = level_q[LVL_W-1:0];
    assign TEMPO    = tempo_q;
    assign BUSY     = busy_q;
    assign WIN      = win_q;
    assign LOSE     = lose_q;

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Self-checking bench for genius_round_ctrl (SEQ_MAX=3, TIMEOUT=9, SHOW_TICKS=2).
module tb_genius_round_ctrl;

    localparam int unsigned SIZE  = 4;
    localparam int unsigned LVL_W = 4;

    logic             CLKT;
    logic             R;
    logic             START;
    logic             TICK;
    logic [1:0]       SEQ_COLOR;
    logic [3:0]       BTN;
    logic             PAUSE;
    logic [LVL_W-1:0] SEQ_ADDR;
    logic [3:0]       LED;
    logic [SIZE-1:0]  TEMPO;
    logic [LVL_W-1:0] LEVEL;
    logic             BUSY;
    logic             WIN;
    logic             LOSE;

    logic [1:0] mem [16];
    logic [3:0] exp_q [$];
    int checks;
    int failures;

    assign SEQ_COLOR = mem[SEQ_ADDR];

    genius_round_ctrl #(
        .SIZE(SIZE), .LVL_W(LVL_W), .SEQ_MAX(3), .TIMEOUT(9), .SHOW_TICKS(2)
    ) dut (
        .CLKT(CLKT), .R(R), .START(START), .TICK(TICK),
        .SEQ_COLOR(SEQ_COLOR), .BTN(BTN),
`ifdef GENIUS_PAUSE_EN
        .PAUSE(PAUSE),
`endif
        .SEQ_ADDR(SEQ_ADDR), .LED(LED), .TEMPO(TEMPO), .LEVEL(LEVEL),
        .BUSY(BUSY), .WIN(WIN), .LOSE(LOSE)
    );

    initial CLKT = 1'b0;
    always #5 CLKT = ~CLKT;

    function automatic logic [3:0] oh(input logic [1:0] c);
        logic [3:0] r;
        case (c)
            2'd0: r = 4'b0001;
            2'd1: r = 4'b0010;
            2'd2: r = 4'b0100;
            default: r = 4'b1000;
        endcase
        return r;
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic t, input logic [3:0] b, input logic s);
        TICK = t; BTN = b; START = s;
        @(posedge CLKT); #1;
        TICK = 1'b0; BTN = 4'b0000; START = 1'b0;
    endtask

    // Expects SHOW_ON at address 0; checks playback of lvl steps, ends in INPUT.
    task automatic play_round(input int lvl);
        logic [3:0] e;
        for (int i = 0; i < lvl; i++) exp_q.push_back(oh(mem[i]));
        for (int i = 0; i < lvl; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (LED !== e) begin failures++; $display("FAIL show_led_on step=%0d got=%b want=%b", i, LED, e); end
            checks++;
            if (SEQ_ADDR !== LVL_W'(i)) begin failures++; $display("FAIL show_addr step=%0d got=%0d want=%0d", i, SEQ_ADDR, i); end
            step(1'b1, 4'b0000, 1'b0);
            checks++;
            if (LED !== e) begin failures++; $display("FAIL show_led_hold step=%0d got=%b want=%b", i, LED, e); end
            step(1'b1, 4'b0000, 1'b0);
            checks++;
            if (LED !== 4'b0000 || BUSY !== 1'b1) begin failures++; $display("FAIL show_off step=%0d got led=%b busy=%b want led=0000 busy=1", i, LED, BUSY); end
            step(1'b1, 4'b0000, 1'b0);
        end
        checks++;
        if (SEQ_ADDR !== '0 || TEMPO !== '0 || LED !== 4'b0000 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL input_entry got addr=%0d tempo=%0d led=%b busy=%b want 0 0 0000 1", SEQ_ADDR, TEMPO, LED, BUSY);
        end
    endtask

    task automatic complete_round(input int lvl);
        play_round(lvl);
        for (int i = 0; i < lvl; i++) begin
            step(1'b0, oh(mem[i]), 1'b0);
            if (i < lvl - 1) begin
                checks++;
                if (SEQ_ADDR !== LVL_W'(i + 1) || TEMPO !== '0) begin
                    failures++;
                    $display("FAIL press_advance got addr=%0d tempo=%0d want addr=%0d tempo=0", SEQ_ADDR, TEMPO, i + 1);
                end
            end
        end
    endtask

    task automatic test_reset;
        R = 1'b1;
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        R = 1'b0;
        checks++;
        if ({SEQ_ADDR, LED, TEMPO, LEVEL, BUSY, WIN, LOSE} !== '0) begin
            failures++;
            $display("FAIL reset_values got addr=%0d led=%b tempo=%0d level=%0d busy=%b win=%b lose=%b want all 0",
                     SEQ_ADDR, LED, TEMPO, LEVEL, BUSY, WIN, LOSE);
        end
    endtask

    task automatic test_show_first_press;
        step(1'b0, 4'b0000, 1'b1);
        checks++;
        if (LEVEL !== 4'd1 || BUSY !== 1'b1) begin failures++; $display("FAIL start_level got level=%0d busy=%b want 1 1", LEVEL, BUSY); end
        play_round(1);
        step(1'b0, 4'b0100, 1'b0);
        checks++;
        if (LEVEL !== 4'd2 || SEQ_ADDR !== '0 || BUSY !== 1'b1 || LED !== 4'b0000) begin
            failures++;
            $display("FAIL gap_entry got level=%0d addr=%0d busy=%b led=%b want 2 0 1 0000", LEVEL, SEQ_ADDR, BUSY, LED);
        end
    endtask

    task automatic test_wrong_press;
        step(1'b1, 4'b0000, 1'b0);
        play_round(2);
        step(1'b0, 4'b0100, 1'b0);
        checks++;
        if (SEQ_ADDR !== 4'd1 || BUSY !== 1'b1) begin failures++; $display("FAIL wrong_first got addr=%0d busy=%b want 1 1", SEQ_ADDR, BUSY); end
        step(1'b0, 4'b0010, 1'b0);
        checks++;
        if (LOSE !== 1'b1 || BUSY !== 1'b0 || WIN !== 1'b0 || LEVEL !== 4'd2) begin
            failures++;
            $display("FAIL wrong_lose got lose=%b busy=%b win=%b level=%0d want 1 0 0 2", LOSE, BUSY, WIN, LEVEL);
        end
        step(1'b1, 4'b0001, 1'b0);
        checks++;
        if (LOSE !== 1'b1 || LEVEL !== 4'd2) begin failures++; $display("FAIL lose_hold got lose=%b level=%0d want 1 2", LOSE, LEVEL); end
    endtask

    task automatic test_timeout;
        step(1'b0, 4'b0000, 1'b1);
        play_round(1);
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 4'b0000, 1'b0);
            checks++;
            if (TEMPO !== SIZE'(k) || BUSY !== 1'b1) begin failures++; $display("FAIL tempo_count got tempo=%0d busy=%b want %0d 1", TEMPO, BUSY, k); end
        end
        step(1'b1, 4'b0000, 1'b0);
        checks++;
        if (LOSE !== 1'b1 || TEMPO !== 4'd9 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL timeout_lose got lose=%b tempo=%0d busy=%b want 1 9 0", LOSE, TEMPO, BUSY);
        end
        step(1'b1, 4'b0000, 1'b0);
        checks++;
        if (TEMPO !== 4'd9) begin failures++; $display("FAIL tempo_hold got %0d want 9", TEMPO); end
        step(1'b0, 4'b0000, 1'b1);
        play_round(1);
        for (int k = 1; k <= 9; k++) step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        checks++;
        if (TEMPO !== '0 || LOSE !== 1'b0 || LEVEL !== 4'd2 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL btn_over_tick got tempo=%0d lose=%b level=%0d busy=%b want 0 0 2 1", TEMPO, LOSE, LEVEL, BUSY);
        end
    endtask

    task automatic test_win;
        R = 1'b1; step(1'b0, 4'b0000, 1'b0); R = 1'b0;
        step(1'b0, 4'b0000, 1'b1);
        complete_round(1);
        step(1'b1, 4'b0000, 1'b0);
        complete_round(2);
        step(1'b1, 4'b0000, 1'b0);
        complete_round(3);
        checks++;
        if (WIN !== 1'b1 || BUSY !== 1'b0 || LOSE !== 1'b0 || LEVEL !== 4'd3) begin
            failures++;
            $display("FAIL win got win=%b busy=%b lose=%b level=%0d want 1 0 0 3", WIN, BUSY, LOSE, LEVEL);
        end
        step(1'b0, 4'b0001, 1'b0);
        checks++;
        if (WIN !== 1'b1 || LOSE !== 1'b0) begin failures++; $display("FAIL win_hold got win=%b lose=%b want 1 0", WIN, LOSE); end
        step(1'b0, 4'b0000, 1'b1);
        checks++;
        if (LEVEL !== 4'd1 || WIN !== 1'b0 || BUSY !== 1'b1 || SEQ_ADDR !== '0 || LED !== oh(mem[0])) begin
            failures++;
            $display("FAIL restart got level=%0d win=%b busy=%b addr=%0d led=%b want 1 0 1 0 %b", LEVEL, WIN, BUSY, SEQ_ADDR, LED, oh(mem[0]));
        end
    endtask

    task automatic test_reset_mid_show;
        complete_round(1);
        step(1'b1, 4'b0000, 1'b0);
        complete_round(2);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        checks++;
        if (LEVEL !== 4'd3 || LED !== oh(mem[0])) begin failures++; $display("FAIL level3_show got level=%0d led=%b want 3 %b", LEVEL, LED, oh(mem[0])); end
        R = 1'b1;
        step(1'b1, 4'b0000, 1'b1);
        R = 1'b0;
        checks++;
        if ({SEQ_ADDR, LED, TEMPO, LEVEL, BUSY, WIN, LOSE} !== '0) begin
            failures++;
            $display("FAIL reset_mid got addr=%0d led=%b tempo=%0d level=%0d busy=%b win=%b lose=%b want all 0",
                     SEQ_ADDR, LED, TEMPO, LEVEL, BUSY, WIN, LOSE);
        end
    endtask

    task automatic test_start_ignored_multibit;
        step(1'b0, 4'b0000, 1'b1);
        play_round(1);
        step(1'b0, 4'b0000, 1'b1);
        checks++;
        if (BUSY !== 1'b1 || LEVEL !== 4'd1 || LED !== 4'b0000 || SEQ_ADDR !== '0) begin
            failures++;
            $display("FAIL start_ignored got busy=%b level=%0d led=%b addr=%0d want 1 1 0000 0", BUSY, LEVEL, LED, SEQ_ADDR);
        end
        step(1'b0, 4'b0101, 1'b0);
        checks++;
        if (LOSE !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL multibit_lose got lose=%b busy=%b want 1 0", LOSE, BUSY); end
    endtask

`ifdef GENIUS_PAUSE_EN
    task automatic test_pause;
        step(1'b0, 4'b0000, 1'b1);
        play_round(1);
        for (int k = 0; k < 3; k++) step(1'b1, 4'b0000, 1'b0);
        PAUSE = 1'b1;
        for (int k = 0; k < 5; k++) step(1'b1, 4'b0000, 1'b0);
        step(1'b0, oh(mem[0]), 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        checks++;
        if (TEMPO !== 4'd3 || BUSY !== 1'b1 || LEVEL !== 4'd1 || LOSE !== 1'b0 || LED !== 4'b0000) begin
            failures++;
            $display("FAIL pause_hold got tempo=%0d busy=%b level=%0d lose=%b led=%b want 3 1 1 0 0000", TEMPO, BUSY, LEVEL, LOSE, LED);
        end
        PAUSE = 1'b0;
        step(1'b1, 4'b0000, 1'b0);
        checks++;
        if (TEMPO !== 4'd4) begin failures++; $display("FAIL pause_release got tempo=%0d want 4", TEMPO); end
    endtask
`endif

    initial begin
        checks = 0; failures = 0;
        R = 1'b1; START = 1'b0; TICK = 1'b0; BTN = 4'b0000; PAUSE = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 2'd3;
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd1;
        @(posedge CLKT); #1;
        test_reset();
        test_show_first_press();
        test_wrong_press();
        test_timeout();
        test_win();
        test_reset_mid_show();
        test_start_ignored_multibit();
`ifdef GENIUS_PAUSE_EN
        test_pause();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
